layer_scheduler: RTL and testbench

LAYER_SCHEDULER -- requirements
Module: layer_scheduler

---
 rtl/layer_scheduler.sv | 144 ++++++++++++++
 tb/tb_layer_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_scheduler.sv
// Per-pixel layer scan: tests each layer slot for coverage in turn, asks the ACU for an
// address for each covered layer, and emits one fetch per covered layer in slot order.
module layer_scheduler #(
    parameter int NUM_LAYERS  = 8,
    parameter int ACU_TIMEOUT = 64
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    input  logic [15:0]                     xPixel,
    input  logic [15:0]                     yPixel,
    output logic [$clog2(NUM_LAYERS)-1:0]   layer_sel,
    input  logic [127:0]                    layerRegisters,
    output logic                            acu_start,
    output logic [127:0]                    acu_layerRegisters,
    output logic [15:0]                     acu_xPixel,
    output logic [15:0]                     acu_yPixel,
    input  logic                            acu_rdy,
    input  logic [26:0]                     acu_ramAddressOffsetBytes,
    output logic                            fetch_valid,
    input  logic                            fetch_ready,
    output logic [$clog2(NUM_LAYERS)-1:0]   fetch_layer,
    output logic [26:0]                     fetch_addr,
    output logic                            fetch_isSprite,
    output logic                            pix_done,
    output logic [$clog2(NUM_LAYERS):0]     hit_count,
    output logic                            acu_timeout_err
);
    localparam int LW = $clog2(NUM_LAYERS);
    localparam int TW = $clog2(ACU_TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_ISSUE, S_WAIT, S_EMIT, S_DONE} state_t;

    state_t        state, state_next;
    logic          advance, covered, last, timed_out;
    logic [15:0]   x_lat, y_lat;
    logic [TW-1:0] timer;

    // Coverage test on the slot currently addressed; sums are widened so nothing wraps
    logic [15:0] width, height, xpos, ypos;
    logic [3:0]  num_chars;
    logic [19:0] font_span, span_x;
    logic [20:0] x_end;
    logic [16:0] y_end;

    assign width     = layerRegisters[31:16];
    assign height    = layerRegisters[47:32];
    assign xpos      = layerRegisters[63:48];
    assign ypos      = layerRegisters[79:64];
    assign num_chars = layerRegisters[99:96];
    assign font_span = {4'd0, width} * {16'd0, num_chars};
    assign span_x    = layerRegisters[1] ? {4'd0, width} : font_span;
    assign x_end     = {5'd0, xpos} + {1'b0, span_x};
    assign y_end     = {1'b0, ypos} + {1'b0, height};

    assign covered = layerRegisters[0] && (span_x != 20'd0) && (height != 16'd0) &&
                     (x_lat >= xpos) && ({5'd0, x_lat} < x_end) &&
                     (y_lat >= ypos) && ({1'b0, y_lat} < y_end);

    assign last        = (layer_sel == LW'(NUM_LAYERS - 1));
    assign timed_out   = (timer == TW'(ACU_TIMEOUT - 1));
    assign fetch_layer = layer_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        advance     = 1'b0;
        pix_ready   = 1'b0;
        acu_start   = 1'b0;
        fetch_valid = 1'b0;
        pix_done    = 1'b0;
        case (state)
            S_IDLE: begin
                pix_ready = 1'b1;
                if (pix_valid) state_next = S_READ;
            end
            S_READ: begin
                if (covered) state_next = S_ISSUE;
                else         advance    = 1'b1;
            end
            S_ISSUE: begin
                acu_start  = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (acu_rdy)        state_next = S_EMIT;
                else if (timed_out) advance    = 1'b1;
            end
            S_EMIT: begin
                fetch_valid = 1'b1;
                if (fetch_ready) advance = 1'b1;
            end
            S_DONE: begin
                pix_done   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (advance) state_next = last ? S_DONE : S_READ;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_lat              <= '0;
            y_lat              <= '0;
            layer_sel          <= '0;
            hit_count          <= '0;
            timer              <= '0;
            acu_layerRegisters <= '0;
            acu_xPixel         <= '0;
            acu_yPixel         <= '0;
            fetch_addr         <= '0;
            fetch_isSprite     <= 1'b0;
            acu_timeout_err    <= 1'b0;
        end else begin
            if (state == S_IDLE && pix_valid) begin
                x_lat     <= xPixel;
                y_lat     <= yPixel;
                hit_count <= '0;
                layer_sel <= '0;
            end
            // ACU command is captured on the way into ISSUE and held until the next covered slot
            if (state == S_READ && covered) begin
                acu_layerRegisters <= layerRegisters;
                acu_xPixel         <= x_lat;
                acu_yPixel         <= y_lat;
            end
            if (state == S_ISSUE)     timer <= '0;
            else if (state == S_WAIT) timer <= timer + TW'(1);
            if (state == S_WAIT && acu_rdy) begin
                fetch_addr     <= acu_ramAddressOffsetBytes;
                fetch_isSprite <= acu_layerRegisters[1];
            end
            if (state == S_WAIT && !acu_rdy && timed_out) acu_timeout_err <= 1'b1;
            if (state == S_EMIT && fetch_ready) hit_count <= hit_count + (LW+1)'(1);
            if (advance && !last) layer_sel <= layer_sel + LW'(1);
        end
    end
endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: directed vector table, randomized scans against a coverage
// model, and hand sequences for ACU timeout, fetch back-pressure and mid-scan reset.
module tb_layer_scheduler;
    localparam int NL = 8;

    logic         clk = 1'b0, reset = 1'b0;
    logic         pix_valid, pix_ready;
    logic [15:0]  xPixel, yPixel;
    logic [2:0]   layer_sel;
    logic [127:0] layerRegisters;
    logic         acu_start;
    logic [127:0] acu_layerRegisters;
    logic [15:0]  acu_xPixel, acu_yPixel;
    logic         acu_rdy = 1'b0;
    logic [26:0]  acu_ramAddressOffsetBytes = '0;
    logic         fetch_valid, fetch_ready = 1'b0;
    logic [2:0]   fetch_layer;
    logic [26:0]  fetch_addr;
    logic         fetch_isSprite, pix_done, acu_timeout_err;
    logic [3:0]   hit_count;

    layer_scheduler #(.NUM_LAYERS(NL), .ACU_TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .xPixel(xPixel), .yPixel(yPixel), .layer_sel(layer_sel), .layerRegisters(layerRegisters),
        .acu_start(acu_start), .acu_layerRegisters(acu_layerRegisters), .acu_xPixel(acu_xPixel),
        .acu_yPixel(acu_yPixel), .acu_rdy(acu_rdy), .acu_ramAddressOffsetBytes(acu_ramAddressOffsetBytes),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_layer(fetch_layer),
        .fetch_addr(fetch_addr), .fetch_isSprite(fetch_isSprite), .pix_done(pix_done),
        .hit_count(hit_count), .acu_timeout_err(acu_timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct { int layer; logic [26:0] addr; logic spr; } fetch_t;
    typedef struct { int sa; logic [127:0] ra; int sb; logic [127:0] rb;
                     int x; int y; int d; int hits; int lat; } vec_t;

    logic [127:0] regs [NL];
    assign layerRegisters = regs[layer_sel];

    int checks = 0, errors = 0;
    int cyc = 0, t0 = 0, n_start = 0;
    int acu_d = 3, fr_mode = 0;
    bit acu_noise = 0, acu_pend = 0;
    int acu_since = 0;
    fetch_t got[$], exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Address unit: answers acu_d cycles into the wait (0 = never), with an address built
    // from the tag field of the slot and the pixel it was handed; random rdy glitches when idle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            acu_pend <= 0; acu_since <= 0; acu_rdy <= 0; acu_ramAddressOffsetBytes <= '0;
        end else if (acu_start) begin
            acu_pend <= 1; acu_since <= 1; acu_rdy <= (acu_d == 1);
            acu_ramAddressOffsetBytes <= (acu_d == 1) ?
                {acu_layerRegisters[114:104], acu_xPixel[7:0], acu_yPixel[7:0]} : 27'($urandom);
        end else if (acu_pend) begin
            acu_since <= acu_since + 1;
            if (acu_rdy) begin
                acu_pend <= 0; acu_rdy <= 0; acu_ramAddressOffsetBytes <= 27'($urandom);
            end else begin
                acu_rdy <= (acu_d != 0 && acu_since + 1 == acu_d);
                acu_ramAddressOffsetBytes <= {acu_layerRegisters[114:104], acu_xPixel[7:0], acu_yPixel[7:0]};
            end
        end else begin
            acu_rdy <= acu_noise && ($urandom_range(0, 3) == 0);
            acu_ramAddressOffsetBytes <= 27'($urandom);
        end
    end

    always @(posedge clk) begin
        case (fr_mode)
            0:       fetch_ready <= 1'b1;
            1:       fetch_ready <= 1'($urandom_range(0, 1));
            default: fetch_ready <= 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!reset && fetch_valid && fetch_ready)
            got.push_back('{int'(fetch_layer), fetch_addr, fetch_isSprite});
        if (!reset && acu_start) n_start = n_start + 1;
    end

    function automatic logic [127:0] mk(int pop, int spr, int w, int h, int xp, int yp, int nc, int tag);
        logic [127:0] r = '0;
        r[0] = (pop != 0); r[1] = (spr != 0);
        r[31:16] = 16'(w); r[47:32] = 16'(h); r[63:48] = 16'(xp); r[79:64] = 16'(yp);
        r[99:96] = 4'(nc); r[114:104] = 11'(tag);
        return r;
    endfunction

    function automatic bit covers(logic [127:0] r, int x, int y);
        int w = int'(r[31:16]), h = int'(r[47:32]);
        int xp = int'(r[63:48]), yp = int'(r[79:64]), nc = int'(r[99:96]);
        int span = r[1] ? w : w * nc;
        return r[0] && span > 0 && h > 0 && x >= xp && x < xp + span && y >= yp && y < yp + h;
    endfunction

    task automatic build_expected(input int x, input int y);
        exp_q.delete();
        for (int i = 0; i < NL; i++)
            if (covers(regs[i], x, y) && acu_d != 0)
                exp_q.push_back('{i, {regs[i][114:104], 8'(x), 8'(y)}, regs[i][1]});
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_fetch();
        chk("fetch_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk("fetch_layer", got[i].layer, exp_q[i].layer);
            chk("fetch_addr", int'(got[i].addr), int'(exp_q[i].addr));
            chk("fetch_isSprite", int'(got[i].spr), int'(exp_q[i].spr));
        end
    endtask

    task automatic clear_regs();
        for (int i = 0; i < NL; i++) regs[i] = '0;
    endtask

    task automatic start_pixel(input int x, input int y);
        got.delete(); n_start = 0;
        @(negedge clk);
        chk("pix_ready_idle", int'(pix_ready), 1);
        pix_valid = 1; xPixel = 16'(x); yPixel = 16'(y); t0 = cyc;
        @(negedge clk);
        pix_valid = 0; xPixel = 16'($urandom); yPixel = 16'($urandom);
    endtask

    task automatic wait_done(input int exp_hits, output int lat);
        bit seen = 0;
        lat = -1;
        for (int k = 0; k < 3000; k++) begin
            if (pix_done) begin seen = 1; lat = cyc - t0; break; end
            @(negedge clk);
        end
        if (!seen) chk("pix_done_timeout", 0, 1);
        else begin
            chk("hit_count_at_done", int'(hit_count), exp_hits);
            @(negedge clk);
            chk("pix_done_one_cycle", int'(pix_done), 0);
            chk("hit_count_held", int'(hit_count), exp_hits);
        end
    endtask

    vec_t tbl[12];
    int lat;

    initial begin
        pix_valid = 0; xPixel = 0; yPixel = 0;
        clear_regs();
        #1 reset = 1;
        #2;
        chk("rst_pix_ready", int'(pix_ready), 1);
        chk("rst_acu_start", int'(acu_start), 0);
        chk("rst_fetch_valid", int'(fetch_valid), 0);
        chk("rst_pix_done", int'(pix_done), 0);
        chk("rst_hit_count", int'(hit_count), 0);
        chk("rst_layer_sel", int'(layer_sel), 0);
        chk("rst_timeout_err", int'(acu_timeout_err), 0);
        chk("rst_acu_bus", int'(acu_layerRegisters != '0), 0);
        chk("rst_fetch_addr", int'(fetch_addr), 0);
        repeat (2) @(negedge clk);
        reset = 0;

        tbl[0]  = '{-1, '0, -1, '0, 3, 3, 3, 0, 9};
        tbl[1]  = '{1, mk(1,1,16,16,0,0,0,'h123), 5, mk(1,1,16,16,0,0,0,'h456), 15, 15, 3, 2, 19};
        tbl[2]  = '{2, mk(1,1,4,4,10,10,0,7), -1, '0, 14, 10, 3, 0, 9};
        tbl[3]  = '{2, mk(1,1,4,4,10,10,0,7), -1, '0, 10, 14, 3, 0, 9};
        tbl[4]  = '{2, mk(1,1,4,4,10,10,0,7), -1, '0, 13, 13, 3, 1, 14};
        tbl[5]  = '{0, mk(1,0,8,4,0,0,3,9), -1, '0, 23, 0, 3, 1, 14};
        tbl[6]  = '{0, mk(1,0,8,4,0,0,3,9), -1, '0, 24, 0, 3, 0, 9};
        tbl[7]  = '{7, mk(1,1,16,16,'hFFF8,0,0,5), -1, '0, 2, 0, 3, 0, 9};
        tbl[8]  = '{0, mk(1,0,8,8,0,0,0,3), -1, '0, 0, 0, 3, 0, 9};
        tbl[9]  = '{0, mk(0,1,16,16,0,0,0,3), -1, '0, 1, 1, 3, 0, 9};
        tbl[10] = '{7, mk(1,1,2,2,5,5,0,'h7FF), -1, '0, 6, 6, 1, 1, 12};
        tbl[11] = '{6, mk(1,1,16,0,0,0,0,1), -1, '0, 0, 0, 3, 0, 9};

        for (int v = 0; v < 12; v++) begin
            clear_regs();
            if (tbl[v].sa >= 0) regs[tbl[v].sa] = tbl[v].ra;
            if (tbl[v].sb >= 0) regs[tbl[v].sb] = tbl[v].rb;
            acu_d = tbl[v].d; acu_noise = 0; fr_mode = 0;
            build_expected(tbl[v].x, tbl[v].y);
            start_pixel(tbl[v].x, tbl[v].y);
            wait_done(tbl[v].hits, lat);
            chk($sformatf("vec%0d_latency", v), lat, tbl[v].lat);
            chk($sformatf("vec%0d_acu_starts", v), n_start, tbl[v].hits);
            cmp_fetch();
        end

        // Randomized scans with rdy glitches outside the wait and random fetch back-pressure
        for (int it = 0; it < 40; it++) begin
            int x, y;
            for (int i = 0; i < NL; i++)
                regs[i] = mk(int'($urandom_range(0,3) != 0), int'($urandom_range(0,1)),
                             int'($urandom_range(0,15)), int'($urandom_range(0,15)),
                             int'($urandom_range(0,31)), int'($urandom_range(0,31)),
                             int'($urandom_range(0,3)), int'($urandom_range(0,2047)));
            x = int'($urandom_range(0,47)); y = int'($urandom_range(0,47));
            if (it % 8 == 0) regs[0] = mk(1,1,32,64,'hFFF0 + int'($urandom_range(0,15)),0,0,1);
            acu_d = int'($urandom_range(1,5)); acu_noise = 1; fr_mode = int'($urandom_range(0,1));
            build_expected(x, y);
            start_pixel(x, y);
            wait_done(exp_q.size(), lat);
            cmp_fetch();
        end
        acu_noise = 0; fr_mode = 0;
        chk("no_spurious_timeout", int'(acu_timeout_err), 0);

        // ACU never answers: layer skipped after 64 wait cycles, scan still completes
        clear_regs();
        regs[3] = mk(1,1,8,8,0,0,0,12);
        acu_d = 0;
        start_pixel(2, 2);
        wait_done(0, lat);
        chk("timeout_latency", lat, 74);
        chk("timeout_err_set", int'(acu_timeout_err), 1);
        chk("timeout_no_fetch", got.size(), 0);
        chk("timeout_acu_starts", n_start, 1);

        // Fetch back-pressure: outputs must hold while fetch_ready stays low
        clear_regs();
        regs[4] = mk(1,0,4,2,0,0,2,77);
        acu_d = 2; fr_mode = 2;
        build_expected(7, 1);
        start_pixel(7, 1);
        begin
            bit fv = 0;
            for (int k = 0; k < 100; k++) begin
                if (fetch_valid) begin fv = 1; break; end
                @(negedge clk);
            end
            chk("stall_fetch_seen", int'(fv), 1);
        end
        for (int j = 0; j < 10; j++) begin
            chk("stall_valid", int'(fetch_valid), 1);
            chk("stall_layer", int'(fetch_layer), 4);
            chk("stall_addr", int'(fetch_addr), int'({11'd77, 8'd7, 8'd1}));
            chk("stall_isSprite", int'(fetch_isSprite), 0);
            @(negedge clk);
        end
        fr_mode = 0;
        wait_done(1, lat);
        cmp_fetch();
        chk("timeout_err_sticky", int'(acu_timeout_err), 1);

        // Reset in the middle of an ACU wait
        clear_regs();
        regs[0] = mk(1,1,8,8,0,0,0,33);
        acu_d = 0;
        start_pixel(1, 1);
        for (int k = 0; k < 50; k++) begin
            if (n_start != 0) break;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        #2 reset = 1;
        #1;
        chk("arst_pix_ready", int'(pix_ready), 1);
        chk("arst_acu_start", int'(acu_start), 0);
        chk("arst_fetch_valid", int'(fetch_valid), 0);
        chk("arst_hit_count", int'(hit_count), 0);
        chk("arst_layer_sel", int'(layer_sel), 0);
        chk("arst_timeout_err", int'(acu_timeout_err), 0);
        chk("arst_acu_bus", int'(acu_layerRegisters != '0), 0);
        chk("arst_acu_x", int'(acu_xPixel), 0);
        @(negedge clk);
        reset = 0;
        begin
            int dones = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (pix_done) dones++;
            end
            chk("arst_no_pix_done", dones, 0);
        end
        acu_d = 2;
        build_expected(1, 1);
        start_pixel(1, 1);
        wait_done(1, lat);
        chk("post_reset_latency", lat, 13);
        cmp_fetch();
        chk("post_reset_err_clear", int'(acu_timeout_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
